// File: rtl/muldiv_if.sv
// Decode-side handshake and write-back bundle for the iterative multiply/divide sequencer.
interface muldiv_if #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 4
);
    logic              start;
    logic [1:0]        op;
    logic              set_flags;
    logic [REG_AW-1:0] dest_in;
    logic [WIDTH-1:0]  src_a;
    logic [WIDTH-1:0]  src_b;
    logic [3:0]        flags_in;
    logic              busy;
    logic              stall_fetch;
    logic              done;
    logic              wr_en;
    logic [REG_AW-1:0] dest_out;
    logic [WIDTH-1:0]  result;
    logic [3:0]        flags_out;
    logic              err;

    modport master (
        output start, op, set_flags, dest_in, src_a, src_b, flags_in,
        input  busy, stall_fetch, done, wr_en, dest_out, result, flags_out, err
    );

    modport slave (
        input  start, op, set_flags, dest_in, src_a, src_b, flags_in,
        output busy, stall_fetch, done, wr_en, dest_out, result, flags_out, err
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply (and optional restoring divide) sequencer with fetch stall.
// Define MULDIV_DIV_EN to make op=3 an unsigned divide; otherwise op=3 completes as illegal.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on accept
// RUN    | one shift-add / shift-subtract step per cycle, WIDTH steps
// DONE   | one-cycle completion: done, write-back, err valid
module muldiv_seq #(
    parameter int WIDTH      = 32,
    parameter int REG_AW     = 4,
    parameter int EARLY_ZERO = 1
) (
    input  logic clk,
    input  logic rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [1:0]         op_q;
    logic               sf_q;
    logic [3:0]         flags_q;
    logic               neg_q;
    logic [REG_AW-1:0]  dest_q;
    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_out_q;
    logic               err_q;
    logic               nowb_q;

    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               zero_opnd;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] fin_prod;
    logic [WIDTH-1:0]   res_sel;

    function automatic logic [3:0] mk_flags(
        input logic [WIDTH-1:0] res,
        input logic             carry,
        input logic [1:0]       op,
        input logic [3:0]       fin,
        input logic             sf
    );
        if (!sf)
            return fin;
        return {res[WIDTH-1], (res == '0), (op == 2'd0) ? carry : fin[1], fin[0]};
    endfunction

    always_comb begin
        accept    = (state == S_IDLE) && bus.start;
        a_neg     = (bus.op == 2'd2) && bus.src_a[WIDTH-1];
        b_neg     = (bus.op == 2'd2) && bus.src_b[WIDTH-1];
        // The most-negative value negates to itself, which is its correct unsigned magnitude.
        mag_a     = a_neg ? -bus.src_a : bus.src_a;
        mag_b     = b_neg ? -bus.src_b : bus.src_b;
        zero_opnd = (bus.src_a == '0) || (bus.src_b == '0);

        add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        mul_next = {add_sum, prod[WIDTH-1:1]};
        step_next = mul_next;
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_next;

    // prod holds {remainder, dividend/quotient}; quotient bits shift in at the bottom.
    always_comb begin
        rem_sh   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        diff     = rem_sh - {1'b0, mcand};
        div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],   prod[WIDTH-2:0], 1'b1};
    end
`endif

    always_comb begin
`ifdef MULDIV_DIV_EN
        fin_prod = (op_q == 2'd3) ? div_next : (neg_q ? -mul_next : mul_next);
`else
        fin_prod = neg_q ? -step_next : step_next;
`endif
        res_sel = ((op_q == 2'd0) || (op_q == 2'd3)) ? fin_prod[WIDTH-1:0]
                                                     : fin_prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            prod        <= '0;
            mcand       <= '0;
            op_q        <= '0;
            sf_q        <= 1'b0;
            flags_q     <= '0;
            neg_q       <= 1'b0;
            dest_q      <= '0;
            result_q    <= '0;
            flags_out_q <= '0;
            err_q       <= 1'b0;
            nowb_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.op;
                        sf_q    <= bus.set_flags;
                        flags_q <= bus.flags_in;
                        dest_q  <= bus.dest_in;
                        cnt     <= '0;
                        neg_q   <= 1'b0;
                        err_q   <= 1'b0;
                        nowb_q  <= 1'b0;
                        if (bus.op == 2'd3) begin
`ifdef MULDIV_DIV_EN
                            if (bus.src_b == '0) begin
                                state       <= S_DONE;
                                result_q    <= '1;
                                err_q       <= 1'b1;
                                flags_out_q <= bus.flags_in;
                            end else begin
                                state <= S_RUN;
                                prod  <= {{WIDTH{1'b0}}, bus.src_a};
                                mcand <= bus.src_b;
                            end
`else
                            state       <= S_DONE;
                            result_q    <= '0;
                            err_q       <= 1'b1;
                            nowb_q      <= 1'b1;
                            flags_out_q <= bus.flags_in;
`endif
                        end else if ((EARLY_ZERO != 0) && zero_opnd) begin
                            state       <= S_DONE;
                            result_q    <= '0;
                            flags_out_q <= mk_flags('0, 1'b0, bus.op, bus.flags_in,
                                                    bus.set_flags);
                        end else begin
                            state <= S_RUN;
                            prod  <= {{WIDTH{1'b0}}, mag_b};
                            mcand <= mag_a;
                            neg_q <= a_neg ^ b_neg;
                        end
                    end
                end
                S_RUN: begin
`ifdef MULDIV_DIV_EN
                    prod <= (op_q == 2'd3) ? div_next : mul_next;
`else
                    prod <= step_next;
`endif
                    if (cnt == CNT_LAST) begin
                        state       <= S_DONE;
                        cnt         <= '0;
                        result_q    <= res_sel;
                        flags_out_q <= mk_flags(res_sel, |fin_prod[2*WIDTH-1:WIDTH],
                                                op_q, flags_q, sf_q);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy        = (state != S_IDLE);
        bus.stall_fetch = (state != S_IDLE) || accept;
        bus.done        = (state == S_DONE);
        bus.wr_en       = (state == S_DONE) && !nowb_q;
        bus.err         = (state == S_DONE) && err_q;
        bus.dest_out    = dest_q;
        bus.result      = result_q;
        bus.flags_out   = flags_out_q;
    end
endmodule
